// File: rtl/nios_debug_ocimem_arbiter_pkg.sv
// Shared types and JTAG jdo field positions for the OCI RAM arbiter.
package nios_debug_ocimem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AV_RD = 2'd1,
    JT_RD = 2'd2
  } arb_state_t;

  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_RDFLAG   = 35;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_DATA_LSB = 3;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] data;
  } pend_op_t;

endpackage

// File: rtl/nios_debug_jtag_op_latch.sv
// One-entry pending slot for JTAG OCI memory ops; a new op overwrites an
// unissued one and raises a sticky overrun flag.
module nios_debug_jtag_op_latch
  import nios_debug_ocimem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  input  logic        issue,
  output pend_op_t    pend,
  output logic        overrun
);

  pend_op_t new_op;
  logic     jdo_unused;

  assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

  // ocimem_a only yields an op when its read flag is set; it still masks the
  // lower-priority pulses in the same cycle.
  always_comb begin
    new_op          = '0;
    new_op.data     = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    if (take_action_ocimem_a) begin
      new_op.valid  = jdo[JDO_RDFLAG];
    end else if (take_action_ocimem_b) begin
      new_op.valid    = 1'b1;
      new_op.is_write = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      new_op.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend    <= '0;
      overrun <= 1'b0;
    end else begin
      if (new_op.valid) begin
        pend <= new_op;
        if (pend.valid && !issue) overrun <= 1'b1;
      end else if (issue) begin
        pend.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nios_debug_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM between JTAG debug ops and the Avalon
// debug_mem_slave, alternating grants when both sides are waiting.
//
// state | meaning
// IDLE  | arbitrate; writes complete here, reads issue ram_re
// AV_RD | RAM data returned to Avalon, waitrequest released
// JT_RD | RAM data captured into MonDReg, jtag_addr advances
module nios_debug_ocimem_arbiter
  import nios_debug_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic              avs_waitrequest,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  arb_state_t        state, state_nxt;
  pend_op_t          pend;
  logic [ADDR_W-1:0] jtag_addr;
  logic              last_jtag;
  logic              avs_req;
  logic              grant_jtag;
  logic              grant_av;

  nios_debug_jtag_op_latch u_op_latch (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .issue                   (grant_jtag),
    .pend                    (pend),
    .overrun                 (jtag_overrun)
  );

  assign avs_req    = avs_read | avs_write;
  assign grant_jtag = (state == IDLE) && pend.valid && (!avs_req || !last_jtag);
  assign grant_av   = (state == IDLE) && !grant_jtag && avs_req;
  assign avs_readdata = ram_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_jtag && !pend.is_write)  state_nxt = JT_RD;
        else if (grant_av && avs_read)     state_nxt = AV_RD;
      end
      AV_RD:   state_nxt = IDLE;
      JT_RD:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset_n so a held Avalon write cannot see a zero-wait grant
  // while the block is still in reset.
  always_comb begin
    avs_waitrequest = 1'b1;
    ram_addr        = jtag_addr;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    ram_be          = 4'hF;
    ram_wdata       = pend.data;
    if (reset_n) begin
      case (state)
        IDLE: begin
          if (grant_jtag) begin
            ram_we = pend.is_write;
            ram_re = !pend.is_write;
          end else if (grant_av) begin
            ram_addr = avs_address;
            if (avs_read) begin
              ram_re = 1'b1;
            end else begin
              ram_we          = 1'b1;
              ram_be          = avs_byteenable;
              ram_wdata       = avs_writedata;
              avs_waitrequest = 1'b0;
            end
          end
        end
        AV_RD:   avs_waitrequest = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_addr     <= '0;
      last_jtag     <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
    end else begin
      if (grant_jtag)    last_jtag <= 1'b1;
      else if (grant_av) last_jtag <= 1'b0;

      // A fresh address load wins over the post-op increment.
      if (take_action_ocimem_a)
        jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if ((grant_jtag && pend.is_write) || (state == JT_RD))
        jtag_addr <= jtag_addr + ADDR_W'(1);

      monitor_ready <= (state == JT_RD);
      if (state == JT_RD) MonDReg <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_nios_debug_ocimem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized mixed traffic
// checked against a word-level memory model and fairness bounds.
module tb_nios_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic [7:0]  ram_addr;
  logic        ram_we, ram_re;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  logic [31:0] mem   [256];
  logic [31:0] model [256];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  nios_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun)
  );

  // Single-port RAM with one-cycle read latency; pl_* is a bench-side loader.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    step();
    pl_we = 1'b0;
  endtask

  task automatic pulse_a(input logic rd, input logic [7:0] a);
    jdo = jdo_a(rd, a);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic pulse_n();
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_mr(output bit ok, output logic [31:0] d);
    ok = 1'b0;
    d = '0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (monitor_ready) begin
        ok = 1'b1;
        d = MonDReg;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    avs_address = '0; avs_read = 1'b1; avs_write = 1'b1;
    avs_writedata = '0; avs_byteenable = 4'hF;
    pl_we = 0; pl_addr = '0; pl_data = '0;
    repeat (2) step();
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b1) $display("FAIL reset_waitrequest got %0b want 1", avs_waitrequest); else passes++;
    checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got %0b want 0", ram_we); else passes++;
    checks++; if (ram_re !== 1'b0) $display("FAIL reset_ram_re got %0b want 0", ram_re); else passes++;
    checks++; if (MonDReg !== 32'h0) $display("FAIL reset_MonDReg got %h want 0", MonDReg); else passes++;
    checks++; if (monitor_ready !== 1'b0) $display("FAIL reset_monitor_ready got %0b want 0", monitor_ready); else passes++;
    checks++; if (jtag_overrun !== 1'b0) $display("FAIL reset_overrun got %0b want 0", jtag_overrun); else passes++;
    step();
    avs_read = 0; avs_write = 0;
    step();
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_jtag_read();
    bit ok;
    logic [31:0] d;
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'h11111111);
    pulse_a(1'b1, 8'h10);
    @(negedge clk);
    checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h10)
      $display("FAIL jrd_issue got re=%0b addr=%h want re=1 addr=10", ram_re, ram_addr); else passes++;
    step(); @(negedge clk);
    checks++; if (monitor_ready !== 1'b0) $display("FAIL jrd_mr_early got %0b want 0", monitor_ready); else passes++;
    step(); @(negedge clk);
    checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF)
      $display("FAIL jrd_data got mr=%0b data=%h want mr=1 data=deadbeef", monitor_ready, MonDReg); else passes++;
    step(); @(negedge clk);
    checks++; if (monitor_ready !== 1'b0) $display("FAIL jrd_mr_pulse got %0b want 0", monitor_ready); else passes++;
    step();
    pulse_n();
    @(negedge clk);
    checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h11)
      $display("FAIL jrd_incr got re=%0b addr=%h want re=1 addr=11", ram_re, ram_addr); else passes++;
    step();
    wait_mr(ok, d);
    checks++; if (!ok || d !== 32'h11111111) $display("FAIL jrd_next got ok=%0b data=%h want 11111111", ok, d); else passes++;
  endtask

  task automatic test_wrap();
    preload(8'hFE, 32'h0); preload(8'hFF, 32'h0); preload(8'h00, 32'h0);
    jdo = jdo_a(1'b0, 8'hFE);
    take_action_ocimem_a = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = jdo_b(32'hA); step();
    jdo = jdo_b(32'hB); step();
    jdo = jdo_b(32'hC); step();
    take_action_ocimem_b = 1'b0;
    repeat (3) step();
    checks++; if (mem[8'hFE] !== 32'hA) $display("FAIL wrap_fe got %h want a", mem[8'hFE]); else passes++;
    checks++; if (mem[8'hFF] !== 32'hB) $display("FAIL wrap_ff got %h want b", mem[8'hFF]); else passes++;
    checks++; if (mem[8'h00] !== 32'hC) $display("FAIL wrap_00 got %h want c", mem[8'h00]); else passes++;
    checks++; if (jtag_overrun !== 1'b0) $display("FAIL wrap_no_overrun got %0b want 0", jtag_overrun); else passes++;
  endtask

  task automatic test_avalon_write();
    preload(8'h20, 32'hAAAAAAAA);
    avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h12345678; avs_byteenable = 4'b0011;
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b0) $display("FAIL avw_zero_wait got %0b want 0", avs_waitrequest); else passes++;
    checks++; if (ram_we !== 1'b1 || ram_be !== 4'b0011 || ram_addr !== 8'h20)
      $display("FAIL avw_strobe got we=%0b be=%b addr=%h want we=1 be=0011 addr=20", ram_we, ram_be, ram_addr); else passes++;
    step();
    avs_write = 1'b0; avs_read = 1'b1;
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b1) $display("FAIL avr_wait got %0b want 1", avs_waitrequest); else passes++;
    step(); @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'hAAAA5678)
      $display("FAIL avr_data got wr=%0b data=%h want wr=0 data=aaaa5678", avs_waitrequest, avs_readdata); else passes++;
    step();
    avs_read = 1'b0;
  endtask

  task automatic test_overrun();
    bit ok;
    logic [31:0] d;
    int cnt;
    logic [31:0] dd;
    preload(8'h05, 32'h05050505);
    preload(8'h30, 32'h30303030);
    preload(8'h31, 32'h31313131);
    pulse_a(1'b1, 8'h30);
    wait_mr(ok, d);
    checks++; if (!ok || d !== 32'h30303030) $display("FAIL ovr_setup got ok=%0b data=%h want 30303030", ok, d); else passes++;
    avs_read = 1'b1; avs_address = 8'h05; take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h05)
      $display("FAIL ovr_av_grant got re=%0b addr=%h want re=1 addr=05", ram_re, ram_addr); else passes++;
    step(); @(negedge clk);
    checks++; if (jtag_overrun !== 1'b0) $display("FAIL ovr_not_yet got %0b want 0", jtag_overrun); else passes++;
    checks++; if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h05050505)
      $display("FAIL ovr_av_data got wr=%0b data=%h want wr=0 data=05050505", avs_waitrequest, avs_readdata); else passes++;
    step();
    take_no_action_ocimem_a = 1'b0; avs_read = 1'b0;
    @(negedge clk);
    checks++; if (jtag_overrun !== 1'b1) $display("FAIL ovr_flag got %0b want 1", jtag_overrun); else passes++;
    cnt = 0; dd = '0;
    for (int i = 0; i < 8; i++) begin
      if (monitor_ready) begin cnt++; dd = MonDReg; end
      step(); @(negedge clk);
    end
    step();
    checks++; if (cnt != 1 || dd !== 32'h31313131)
      $display("FAIL ovr_single_read got count=%0d data=%h want count=1 data=31313131", cnt, dd); else passes++;
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    preload(8'h50, 32'h50505050);
    pulse_a(1'b1, 8'h50);
    @(negedge clk);
    checks++; if (ram_re !== 1'b1 || ram_addr !== 8'h50)
      $display("FAIL rst_rd_issue got re=%0b addr=%h want re=1 addr=50", ram_re, ram_addr); else passes++;
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b0)
      $display("FAIL rst_mid_regs got data=%h mr=%0b want 0 0", MonDReg, monitor_ready); else passes++;
    checks++; if (avs_waitrequest !== 1'b1 || ram_re !== 1'b0 || jtag_overrun !== 1'b0)
      $display("FAIL rst_mid_outs got wr=%0b re=%0b ovr=%0b want 1 0 0", avs_waitrequest, ram_re, jtag_overrun); else passes++;
    step(); step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (monitor_ready) seen = 1'b1;
      step();
    end
    checks++; if (seen || MonDReg !== 32'h0)
      $display("FAIL rst_no_pulse got seen=%0b data=%h want 0 0", seen, MonDReg); else passes++;
    avs_write = 1'b1; avs_address = 8'h60; avs_writedata = 32'h6; avs_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (avs_waitrequest !== 1'b0) $display("FAIL rst_idle got wr=%0b want 0", avs_waitrequest); else passes++;
    step();
    avs_write = 1'b0;
  endtask

  task automatic test_alternation();
    int last_kind, wait_run, k, n_av, c;
    bit done;
    preload(8'h05, 32'h05050505);
    for (int i = 0; i < 16; i++) preload(8'h40 + 8'(i), 32'hC0DE0040 + 32'(i));
    pulse_a(1'b0, 8'h40);
    avs_read = 1'b1; avs_address = 8'h05;
    last_kind = 0; wait_run = 0; k = 0; n_av = 0; done = 1'b0;
    for (c = 0; c < 60; c++) begin
      take_no_action_ocimem_a = (c < 30) && (c % 3 == 0);
      @(negedge clk);
      if (ram_re) begin
        if (ram_addr == 8'h05) last_kind = 1;
        else begin
          checks++; if (last_kind == 2) $display("FAIL alt_jtag_twice got two jtag grants cycle %0d", c); else passes++;
          last_kind = 2;
        end
      end
      if (monitor_ready) begin
        checks++; if (MonDReg !== 32'hC0DE0040 + 32'(k))
          $display("FAIL alt_jtag_data got %h want %h", MonDReg, 32'hC0DE0040 + 32'(k)); else passes++;
        k++;
      end
      if (avs_waitrequest) wait_run++;
      else begin
        checks++; if (wait_run > 3 || avs_readdata !== 32'h05050505)
          $display("FAIL alt_av got waits=%0d data=%h want waits<=3 data=05050505", wait_run, avs_readdata); else passes++;
        wait_run = 0;
        n_av++;
        if (c >= 36) done = 1'b1;
      end
      step();
      if (done) break;
    end
    avs_read = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    checks++; if (!done || k < 5 || n_av < 5)
      $display("FAIL alt_progress got done=%0b jtag=%0d av=%0d want 1 >=5 >=5", done, k, n_av); else passes++;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) model[i] = mem[i];
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [7:0] a;
          logic wr;
          logic [3:0] be;
          logic [31:0] d;
          int waits;
          bit got;
          a = 8'($urandom_range(0, 127));
          wr = 1'($urandom_range(0, 1));
          be = 4'($urandom);
          d = $urandom;
          avs_address = a; avs_writedata = d; avs_byteenable = be;
          avs_write = wr; avs_read = !wr;
          waits = 0; got = 1'b0;
          for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
              got = 1'b1;
              if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
              end else begin
                checks++; if (avs_readdata !== model[a])
                  $display("FAIL rnd_av_read addr=%h got %h want %h", a, avs_readdata, model[a]); else passes++;
              end
              break;
            end
            waits++;
            step();
          end
          if (got) step();
          checks++; if (!got || waits > (wr ? 2 : 3))
            $display("FAIL rnd_av_fair got done=%0b waits=%0d want done=1 waits<=%0d", got, waits, wr ? 2 : 3); else passes++;
          avs_read = 1'b0; avs_write = 1'b0;
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        bit ok;
        logic [31:0] d;
        jdo = jdo_a(1'b0, 8'h80);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
          d = $urandom;
          model[8'h80 + 8'(i)] = d;
          jdo = jdo_b(d);
          take_action_ocimem_b = 1'b1;
          step();
          take_action_ocimem_b = 1'b0;
          repeat ($urandom_range(3, 5)) step();
        end
        pulse_a(1'b1, 8'h80);
        wait_mr(ok, d);
        checks++; if (!ok || d !== model[8'h80])
          $display("FAIL rnd_jtag_read idx=0 got ok=%0b data=%h want %h", ok, d, model[8'h80]); else passes++;
        for (int i = 1; i < 16; i++) begin
          pulse_n();
          wait_mr(ok, d);
          checks++; if (!ok || d !== model[8'h80 + 8'(i)])
            $display("FAIL rnd_jtag_read idx=%0d got ok=%0b data=%h want %h", i, ok, d, model[8'h80 + 8'(i)]); else passes++;
        end
      end
    join
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_jtag_read();
    test_wrap();
    test_avalon_write();
    test_overrun();
    test_reset_mid_read();
    test_alternation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
